// File: rtl/cpu_imem.sv
// Instruction memory with a byte-stream program loader.
// Registered big-endian fetch port; RUN/LOAD control FSM.
module cpu_imem #(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [31:0] FILL_WORD  = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] imem_address_i,
  output logic [31:0] imem_data_o,
  input  logic        load_start_i,
  input  logic        load_valid_i,
  input  logic [7:0]  load_byte_i,
  input  logic        load_end_i,
  output logic        load_ready_o,
  output logic        loading_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {RUN, LOAD} state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [31:0]           asm_q, asm_d;
  logic [31:0]           data_q, data_d;

  logic                  we;
  logic [31:0]           wdata;
  logic [31:0]           asm_acc;
  logic [1:0]            cnt_acc;
  logic [DEPTH_LOG2-1:0] raddr;
  logic                  oor;

  logic [31:0] mem [DEPTH];

  assign raddr        = imem_address_i[DEPTH_LOG2+1:2];
  assign oor          = |imem_address_i[31:DEPTH_LOG2+2];
  assign imem_data_o  = data_q;
  assign loading_o    = (state_q == LOAD);
  assign load_ready_o = (state_q == LOAD);

  // Byte merge: an accepted byte lands at lane 3-cnt (big-endian).
  always_comb begin
    asm_acc = asm_q;
    cnt_acc = cnt_q;
    if (load_valid_i) begin
      asm_acc = asm_q
              | ({24'b0, load_byte_i} << {~cnt_q, 3'b000});
      cnt_acc = cnt_q + 2'd1;
    end
  end

  // Next-state, loader pointers and memory write strobe.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    we      = 1'b0;
    wdata   = asm_acc;
    if (load_start_i) begin
      state_d = LOAD;
      ptr_d   = '0;
      cnt_d   = '0;
      asm_d   = '0;
    end else if (state_q == LOAD) begin
      cnt_d = cnt_acc;
      asm_d = asm_acc;
      if (load_valid_i && cnt_q == 2'd3) begin
        we    = 1'b1;
        asm_d = '0;
        if (&ptr_q) begin
          state_d = RUN;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end else if (load_end_i && cnt_acc != 2'd0) begin
        we = 1'b1;
      end
      if (load_end_i) begin
        state_d = RUN;
        cnt_d   = '0;
        asm_d   = '0;
      end
    end
  end

  // Fetch data: suppressed while loading and on the exit edge.
  always_comb begin
    data_d = mem[raddr];
    if (state_q == LOAD || state_d == LOAD || oor) begin
      data_d = FILL_WORD;
    end
  end

  // Control and fetch registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      ptr_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      data_q  <= FILL_WORD;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
    end
  end

  // Storage array; never cleared so reset keeps loaded code.
  always_ff @(posedge clk_i) begin
    if (we && !rst_i) begin
      mem[ptr_q] <= wdata;
    end
  end

endmodule

// File: tb/tb_cpu_imem.sv
// Directed bench for cpu_imem.
// Vector tables for fetches plus loader corner sequences.
module tb_cpu_imem;

  localparam logic [31:0] FILL = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] data;
  logic        start;
  logic        valid;
  logic [7:0]  lbyte;
  logic        lend;
  logic        ready;
  logic        loading;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } vec_t;

  cpu_imem #(
    .DEPTH_LOG2(8),
    .FILL_WORD (FILL)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_address_i(addr),
    .imem_data_o   (data),
    .load_start_i  (start),
    .load_valid_i  (valid),
    .load_byte_i   (lbyte),
    .load_end_i    (lend),
    .load_ready_o  (ready),
    .loading_o     (loading)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_end();
    lend = 1'b1;
    tick();
    lend = 1'b0;
  endtask

  task automatic send(logic [7:0] b);
    valid = 1'b1;
    lbyte = b;
    tick();
    valid = 1'b0;
  endtask

  task automatic fetch(string nm, logic [31:0] a,
                       logic [31:0] exp);
    addr = a;
    tick();
    chk(nm, data, exp);
  endtask

  function automatic logic [7:0] bv(int i);
    return 8'(i * 7 + 3);
  endfunction

  function automatic logic [31:0] wv(int w);
    return {bv(4*w), bv(4*w+1), bv(4*w+2), bv(4*w+3)};
  endfunction

  vec_t t1 [5];
  vec_t t2 [6];

  initial begin
    rst   = 1'b1;
    addr  = '0;
    start = 1'b0;
    valid = 1'b0;
    lbyte = '0;
    lend  = 1'b0;

    t1[0] = '{32'h0000_0004, 32'h0506_0708};
    t1[1] = '{32'h0000_0000, 32'h0102_0304};
    t1[2] = '{32'h0000_0007, 32'h0506_0708};
    t1[3] = '{32'h0000_0400, FILL};
    t1[4] = '{32'h8000_0000, FILL};

    t2[0] = '{32'h0000_0000, wv(0)};
    t2[1] = '{32'h0000_0004, wv(1)};
    t2[2] = '{32'h0000_0202, wv(128)};
    t2[3] = '{32'h0000_03FC, wv(255)};
    t2[4] = '{32'h0000_03FF, wv(255)};
    t2[5] = '{32'h0000_0400, FILL};

    // reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_data", data, FILL);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_loading", 32'(loading), 32'd0);

    // two-word load
    pulse_start();
    chk("ld_loading", 32'(loading), 32'd1);
    chk("ld_ready", 32'(ready), 32'd1);
    for (int i = 1; i <= 8; i++) send(8'(i));
    chk("ld_fill", data, FILL);
    pulse_end();
    chk("end_loading", 32'(loading), 32'd0);
    for (int i = 0; i < 5; i++)
      fetch($sformatf("t1_%0d", i), t1[i].addr, t1[i].exp);

    // partial word with end on the last byte
    pulse_start();
    send(8'hAA);
    send(8'hBB);
    valid = 1'b1;
    lbyte = 8'hCC;
    lend  = 1'b1;
    tick();
    valid = 1'b0;
    lend  = 1'b0;
    chk("cc_end_run", 32'(loading), 32'd0);
    fetch("cc_w0", 32'h0, 32'hAABB_CC00);
    fetch("cc_w1", 32'h4, 32'h0506_0708);

    // restart mid-word discards partial
    pulse_start();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h11); send(8'h22);
    pulse_start();
    chk("restart_loading", 32'(loading), 32'd1);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    pulse_end();
    fetch("rs_w0", 32'h0, 32'h5566_7788);
    fetch("rs_w1", 32'h4, 32'h0506_0708);

    // reset mid-load
    pulse_start();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h99); send(8'h98);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rl_loading", 32'(loading), 32'd0);
    chk("rl_ready", 32'(ready), 32'd0);
    chk("rl_data", data, FILL);
    fetch("rl_w0", 32'h0, 32'h0102_0304);
    fetch("rl_w1", 32'h4, 32'h0506_0708);

    // reset beats start
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_pri", 32'(loading), 32'd0);

    // start with end is start only; end at count 0 no write
    start = 1'b1;
    lend  = 1'b1;
    tick();
    start = 1'b0;
    lend  = 1'b0;
    chk("se_loading", 32'(loading), 32'd1);
    pulse_end();
    chk("se_done", 32'(loading), 32'd0);
    fetch("se_w0", 32'h0, 32'h0102_0304);

    // full-depth load
    pulse_start();
    for (int i = 0; i < 1023; i++) send(bv(i));
    chk("full_pre", 32'(loading), 32'd1);
    send(bv(1023));
    chk("full_loading", 32'(loading), 32'd0);
    chk("full_ready", 32'(ready), 32'd0);
    valid = 1'b1;
    lbyte = 8'h5A;
    lend  = 1'b1;
    tick();
    chk("run_ready", 32'(ready), 32'd0);
    chk("run_end_ign", 32'(loading), 32'd0);
    valid = 1'b0;
    lend  = 1'b0;
    for (int i = 0; i < 6; i++)
      fetch($sformatf("t2_%0d", i), t2[i].addr, t2[i].exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_imem.md
CPU_IMEM -- requirements
Module: cpu_imem

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of the number of 32-bit words stored (256 words).
REQ-002 The block SHALL have parameter FILL_WORD, default 32'h00000000, meaning the word returned while loading or for out-of-range addresses.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port imem_address_i, input, 32 bits: byte address of the fetch from the CPU.
REQ-006 The block SHALL have port imem_data_o, output, 32 bits: registered fetch data, big-endian.
REQ-007 The block SHALL have port load_start_i, input, 1 bit: a one-cycle pulse that begins a load at word 0.
REQ-008 The block SHALL have port load_valid_i, input, 1 bit: load_byte_i is valid this cycle.
REQ-009 The block SHALL have port load_byte_i, input, 8 bits: program byte, in ascending byte-address order.
REQ-010 The block SHALL have port load_end_i, input, 1 bit: a one-cycle pulse that terminates the load.
REQ-011 The block SHALL have port load_ready_o, output, 1 bit: a byte is accepted when load_valid_i & load_ready_o.
REQ-012 The block SHALL have port loading_o, output, 1 bit: high while in state LOAD.

Function
REQ-013 The block SHALL implement two states: RUN and LOAD.
REQ-014 In RUN, imem_data_o SHALL equal mem[imem_address_i[DEPTH_LOG2+1:2]] as sampled one cycle earlier (read latency 1).
REQ-015 In RUN, imem_address_i[1:0] SHALL be ignored.
REQ-016 If imem_address_i[31:DEPTH_LOG2+2] is nonzero, imem_data_o SHALL be FILL_WORD on the next cycle.
REQ-017 Transition RUN->LOAD SHALL occur on load_start_i; the word pointer SHALL be cleared to 0, the byte counter cleared to 0 and the assembly register cleared.
REQ-018 load_start_i asserted in LOAD SHALL restart the load at word 0 and discard any partially assembled word.
REQ-019 In LOAD, load_ready_o SHALL be 1; in RUN it SHALL be 0.
REQ-020 In LOAD, imem_data_o SHALL be FILL_WORD and memory reads SHALL be suppressed.
REQ-021 Accepted bytes SHALL be placed big-endian: byte 0 -> [31:24], byte 1 -> [23:16], byte 2 -> [15:8], byte 3 -> [7:0].
REQ-022 On acceptance of the 4th byte, the assembled word SHALL be written to mem[word pointer] on that clock edge, the byte counter SHALL wrap to 0, and the word pointer SHALL increment.
REQ-023 When the write to word 2^DEPTH_LOG2-1 completes, the block SHALL return to RUN on the same edge; the word pointer SHALL NOT wrap and no further writes SHALL occur.
REQ-024 On load_end_i with byte counter nonzero, the partial word SHALL be written zero-padded in its low bytes to mem[word pointer], and the state SHALL then become RUN.
REQ-025 On load_end_i with byte counter zero, no write SHALL occur and the state SHALL become RUN.
REQ-026 load_valid_i and load_end_i asserted in the same cycle SHALL accept the byte first, then apply REQ-024/REQ-025 using the updated counter, all on the same edge.
REQ-027 load_end_i and load_valid_i in RUN SHALL be ignored.
REQ-028 load_start_i and load_end_i asserted together SHALL be treated as load_start_i only.
REQ-029 The first fetch after the LOAD->RUN edge SHALL return newly written contents (no stale read).
REQ-030 Memory contents SHALL NOT be cleared by reset; words not written since power-up are undefined.

Reset
REQ-031 With rst_i high at a clock edge, the state SHALL become RUN, imem_data_o FILL_WORD, load_ready_o 0, loading_o 0, and the byte counter and word pointer 0.
REQ-032 Reset during LOAD SHALL abort the load without writing any partial word; completed word writes SHALL be retained.
REQ-033 rst_i SHALL take priority over load_start_i in the same cycle.

Verification
REQ-034 Scenario: pulse load_start_i, send bytes 01 02 03 04 05 06 07 08, pulse load_end_i, present address 0x4 -> the next cycle gives imem_data_o = 32'h05060708, and address 0x0 gives 32'h01020304.
REQ-035 Scenario: load the 3 bytes AA BB CC, with load_end_i coincident with CC -> mem[0] = 32'hAABBCC00 and state RUN on that edge.
REQ-036 Scenario: load 1024 bytes (DEPTH_LOG2=8) -> loading_o falls on the edge that writes word 255, and a 1025th byte is not accepted (load_ready_o = 0).
REQ-037 Scenario: while loading_o is high, present any address -> imem_data_o = FILL_WORD; in RUN, address 0x00000400 -> FILL_WORD.
REQ-038 Scenario: load 01 02 03 04 11 22, then load_start_i, then 55 66 77 88 and load_end_i -> mem[0] = 32'h55667788, and mem[1] keeps its value from before this sequence.
REQ-039 Scenario: assert rst_i after 2 bytes of word 1 -> RUN and load_ready_o 0 on the next cycle, mem[0] intact, mem[1] unchanged.
